// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and its width.
package serial_adder_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell: a + b + cin -> {cout, s}.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Start/done coprocessor adding two WIDTH-bit operands one bit per clock,
// LSB first, through a single full_adder_bit.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic [ST_W-1:0]  dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is only looked at in IDLE; done is a one-cycle pulse
  // and S/Cout/V are valid from that cycle until the next result lands.
  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH:0]   s_cat;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_cout;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
  assign s_cat  = {fa_s, s_sh};
  assign s_next = s_cat[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // Output registers load on the last RUN edge so they are already valid
  // in the DONE cycle; carry at that point is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_cout;
          if (cnt == LAST) begin
            S    <= s_next;
            Cout <= fa_cout;
            V    <= carry ^ fa_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 instance for directed/random operations,
// WIDTH=1 instance for the full-adder truth table.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout, V;
  logic [W-1:0] S;
  logic [ST_W-1:0] dbg_state;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, cout1, v1;
  logic [0:0] s1;
  logic [ST_W-1:0] dbg_state1;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V), .dbg_state(dbg_state)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1), .dbg_state(dbg_state1)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [W+1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition; V from operand/result sign bits.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] sum;
    logic v;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return {sum[W], v, sum[W-1:0]};
  endfunction

  // driver: one operation, optionally disturbing inputs and start mid-RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit disturb);
    int n;
    bit seen;
    bit extra;
    logic [W+1:0] e;
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    exp_q.push_back(ref_add(a, b, c));
    @(negedge clk);
    start = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
    n = 1;
    seen = 0;
    while (!seen && n < 40) begin
      if (done) seen = 1;
      else begin
        if (disturb && n == 3) begin
          A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); start = 1'b1;
        end else if (disturb && n == 4) begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    e = exp_q.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(n), 32'(W + 1));
      check("result", 32'({Cout, V, S}), 32'(e));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    if (disturb) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) extra = 1;
      end
      check("no_extra_done", 32'(extra), 32'd0);
    end
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c);
    int n;
    bit seen;
    logic [1:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    seen = 0;
    while (!seen && n < 10) begin
      if (done1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("w1_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("w1_latency", 32'(n), 32'd2);
      check("w1_sum", 32'(s1), 32'(sum[0]));
      check("w1_cout", 32'(cout1), 32'(sum[1]));
      check("w1_v", 32'(v1), 32'(c ^ sum[1]));
    end
    @(negedge clk);
  endtask

  initial begin
    int last, idle, pulses;
    bit got_done;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'({Cout, V, S}), 32'd0);
    rst_n = 1'b1;

    // directed operands
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    check("t1_s", 32'(S), 32'h96);
    check("t1_cv", 32'({Cout, V}), 32'b01);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h00, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);

    // start held high: back-to-back operations
    @(negedge clk);
    A = 8'd1; B = 8'd2; Cin = 1'b0; start = 1'b1;
    last = -1; idle = 0; pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        check("hold_s", 32'(S), 32'd3);
        if (last >= 0) begin
          check("hold_period", 32'(i - last), 32'd10);
          check("hold_idle", 32'(idle), 32'd1);
        end
        last = i; idle = 0; pulses++;
      end else if (!busy) begin
        idle++;
      end
    end
    start = 1'b0;
    check("hold_pulses", 32'(pulses >= 4), 32'd1);
    repeat (12) @(negedge clk);

    // inputs and start disturbed mid-RUN
    run_op(8'h12, 8'h34, 1'b1, 1);
    run_op(8'hC8, 8'h64, 1'b0, 1);

    // random operations
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);

    // reset mid-RUN
    run_op(8'h40, 8'h40, 1'b0, 0);
    @(negedge clk);
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out", 32'({Cout, V, S}), 32'd0);
    got_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    check("arst_no_done", 32'(got_done), 32'd0);
    rst_n = 1'b1;
    run_op(8'h11, 8'h22, 1'b0, 0);
    run_op(8'h9C, 8'hA5, 1'b1, 0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op1(v[2], v[1], v[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
